// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the DataPath:
// IR / memory status in, every datapath strobe out.
interface control_sequencer_if #(
   parameter int IR_WIDTH = 32
);
   logic [IR_WIDTH-1:0] ir;
   logic                mem_done;
   logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
   logic Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic       read;
   logic       write;
   logic [4:0] alu_op;
   logic       run;
   logic       illegal;

   modport master (
      input  ir, mem_done,
      output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
      output Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
      output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      output read, write, alu_op, run, illegal
   );

   modport slave (
      output ir, mem_done,
      input  PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
      input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      input  read, write, alu_op, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch, decode, then an opcode-selected
// execute sequence; strobes are decoded from state (and opcode in E-states).
module control_sequencer #(
   parameter int IR_WIDTH = 32,
   parameter int OPC_MSB  = 31
) (
   input logic                 clock,
   input logic                 clear,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, F0, F1, F2, E3, E4, E5, E6, E7, HALT
   } state_t;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MD, C_NOP, C_HALT, C_ILL
   } cls_t;

   state_t              state;
   cls_t                cls;
   logic [IR_WIDTH-1:0] ir_w;
   logic [4:0]          opc;
   logic [4:0]          imm_op;
   logic                unused_ir;

   assign ir_w      = bus.ir;
   assign opc       = ir_w[OPC_MSB -: 5];
   assign unused_ir = ^ir_w;

   always_comb begin
      cls = C_ILL;
      unique case (1'b1)
         (opc == 5'd0):                  cls = C_LD;
         (opc == 5'd1):                  cls = C_LDI;
         (opc == 5'd2):                  cls = C_ST;
         (opc >= 5'd3 && opc <= 5'd10):  cls = C_ALU;
         (opc >= 5'd11 && opc <= 5'd13): cls = C_IMM;
         (opc == 5'd14 || opc == 5'd15): cls = C_MD;
         (opc == 5'd26):                 cls = C_NOP;
         (opc == 5'd27):                 cls = C_HALT;
         default:                        cls = C_ILL;
      endcase
   end

   // Immediate forms reuse the register ALU codes for add/and/or.
   always_comb begin
      imm_op = 5'b00011;
      unique case (opc)
         5'd12:   imm_op = 5'b00101;
         5'd13:   imm_op = 5'b00110;
         default: imm_op = 5'b00011;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: state <= F0;
            F0:   state <= F1;
            F1:   if (bus.mem_done) state <= F2;
            F2:   state <= E3;
            E3: begin
               case (cls)
                  C_HALT:       state <= HALT;
                  C_NOP, C_ILL: state <= F0;
                  default:      state <= E4;
               endcase
            end
            E4:   state <= E5;
            E5: begin
               case (cls)
                  C_LD, C_ST, C_MD: state <= E6;
                  default:          state <= F0;
               endcase
            end
            E6: begin
               case (cls)
                  C_LD:    if (bus.mem_done) state <= E7;
                  C_ST:    state <= E7;
                  default: state <= F0;
               endcase
            end
            E7: begin
               if (cls != C_ST || bus.mem_done) state <= F0;
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.PCout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.IRin     = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIout    = 1'b0;
      bus.LOout    = 1'b0;
      bus.Gra      = 1'b0;
      bus.Grb      = 1'b0;
      bus.Grc      = 1'b0;
      bus.Rin      = 1'b0;
      bus.Rout     = 1'b0;
      bus.BAout    = 1'b0;
      bus.Cout     = 1'b0;
      bus.read     = 1'b0;
      bus.write    = 1'b0;
      bus.alu_op   = 5'b00000;
      bus.illegal  = 1'b0;
      bus.run      = (state != HALT);
      case (state)
         F0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = 5'b00011;
         end
         F1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         F2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         E3: begin
            case (cls)
               C_LD, C_LDI, C_ST: begin
                  bus.Grb   = 1'b1;
                  bus.BAout = 1'b1;
                  bus.Yin   = 1'b1;
               end
               C_ALU, C_IMM: begin
                  bus.Grb  = 1'b1;
                  bus.Rout = 1'b1;
                  bus.Yin  = 1'b1;
               end
               C_MD: begin
                  bus.Gra  = 1'b1;
                  bus.Rout = 1'b1;
                  bus.Yin  = 1'b1;
               end
               C_ILL:   bus.illegal = 1'b1;
               default: ;
            endcase
         end
         E4: begin
            case (cls)
               C_LD, C_LDI, C_ST: begin
                  bus.Cout   = 1'b1;
                  bus.Zin    = 1'b1;
                  bus.alu_op = 5'b00011;
               end
               C_ALU: begin
                  bus.Grc    = 1'b1;
                  bus.Rout   = 1'b1;
                  bus.Zin    = 1'b1;
                  bus.alu_op = opc;
               end
               C_IMM: begin
                  bus.Cout   = 1'b1;
                  bus.Zin    = 1'b1;
                  bus.alu_op = imm_op;
               end
               C_MD: begin
                  bus.Grb    = 1'b1;
                  bus.Rout   = 1'b1;
                  bus.Zin    = 1'b1;
                  bus.alu_op = opc;
               end
               default: ;
            endcase
         end
         E5: begin
            case (cls)
               C_LD, C_ST: begin
                  bus.Zlowout = 1'b1;
                  bus.MARin   = 1'b1;
               end
               C_LDI, C_ALU, C_IMM: begin
                  bus.Zlowout = 1'b1;
                  bus.Gra     = 1'b1;
                  bus.Rin     = 1'b1;
               end
               C_MD: begin
                  bus.Zlowout = 1'b1;
                  bus.LOin    = 1'b1;
               end
               default: ;
            endcase
         end
         E6: begin
            case (cls)
               C_LD: begin
                  bus.read  = 1'b1;
                  bus.MDRin = 1'b1;
               end
               C_ST: begin
                  bus.Gra   = 1'b1;
                  bus.Rout  = 1'b1;
                  bus.MDRin = 1'b1;
               end
               C_MD: begin
                  bus.Zhighout = 1'b1;
                  bus.HIin     = 1'b1;
               end
               default: ;
            endcase
         end
         E7: begin
            case (cls)
               C_LD: begin
                  bus.MDRout = 1'b1;
                  bus.Gra    = 1'b1;
                  bus.Rin    = 1'b1;
               end
               C_ST:    bus.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe
// sequences built from the instruction timing tables, with random stalls.
module tb_control_sequencer;

   typedef logic [30:0] vec_t;

   typedef struct {
      vec_t        exp;
      logic        md;
      logic [31:0] ir;
      string       tag;
   } step_t;

   localparam vec_t M_PCOUT  = vec_t'(1 << 30);
   localparam vec_t M_PCIN   = vec_t'(1 << 29);
   localparam vec_t M_INCPC  = vec_t'(1 << 28);
   localparam vec_t M_IRIN   = vec_t'(1 << 27);
   localparam vec_t M_MARIN  = vec_t'(1 << 26);
   localparam vec_t M_MDRIN  = vec_t'(1 << 25);
   localparam vec_t M_MDROUT = vec_t'(1 << 24);
   localparam vec_t M_YIN    = vec_t'(1 << 23);
   localparam vec_t M_ZIN    = vec_t'(1 << 22);
   localparam vec_t M_ZLO    = vec_t'(1 << 21);
   localparam vec_t M_ZHI    = vec_t'(1 << 20);
   localparam vec_t M_HIIN   = vec_t'(1 << 19);
   localparam vec_t M_LOIN   = vec_t'(1 << 18);
   localparam vec_t M_GRA    = vec_t'(1 << 15);
   localparam vec_t M_GRB    = vec_t'(1 << 14);
   localparam vec_t M_GRC    = vec_t'(1 << 13);
   localparam vec_t M_RIN    = vec_t'(1 << 12);
   localparam vec_t M_ROUT   = vec_t'(1 << 11);
   localparam vec_t M_BAOUT  = vec_t'(1 << 10);
   localparam vec_t M_COUT   = vec_t'(1 << 9);
   localparam vec_t M_RD     = vec_t'(1 << 8);
   localparam vec_t M_WR     = vec_t'(1 << 7);
   localparam vec_t M_RUN    = vec_t'(1 << 6);
   localparam vec_t M_ILL    = vec_t'(1 << 5);

   logic clock;
   logic clear;
   int   checks;
   int   errors;
   step_t q[$];

   control_sequencer_if #(.IR_WIDTH(32)) cs_bus ();

   control_sequencer #(
      .IR_WIDTH(32),
      .OPC_MSB (31)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (cs_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t obs();
      return {cs_bus.PCout, cs_bus.PCin, cs_bus.IncPC, cs_bus.IRin,
              cs_bus.MARin, cs_bus.MDRin, cs_bus.MDRout, cs_bus.Yin,
              cs_bus.Zin, cs_bus.Zlowout, cs_bus.Zhighout, cs_bus.HIin,
              cs_bus.LOin, cs_bus.HIout, cs_bus.LOout, cs_bus.Gra,
              cs_bus.Grb, cs_bus.Grc, cs_bus.Rin, cs_bus.Rout,
              cs_bus.BAout, cs_bus.Cout, cs_bus.read, cs_bus.write,
              cs_bus.run, cs_bus.illegal, cs_bus.alu_op};
   endfunction

   task automatic chk(input string tag, input vec_t o, input vec_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic void push(input vec_t e, input logic md,
                                input logic [31:0] ir, input string tag);
      step_t s;
      s.exp = e;
      s.md  = md;
      s.ir  = ir;
      s.tag = tag;
      q.push_back(s);
   endfunction

   // Memory wait: stall cycles with mem_done=0, then the completing cycle.
   function automatic void push_wait(input vec_t e, input int stall,
                                     input logic [31:0] ir,
                                     input string tag);
      for (int i = 0; i < stall; i++) push(e, 1'b0, ir, {tag, "w"});
      push(e, 1'b1, ir, tag);
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // Expected per-cycle outputs from F0 up to the cycle before next F0.
   function automatic void build(input logic [31:0] insn, input int f1s,
                                 input int mems);
      logic [4:0]  op;
      logic [31:0] junk;
      vec_t        r;
      vec_t        immop;
      op    = insn[31:27];
      junk  = $urandom;
      r     = M_RUN;
      immop = (op == 5'd12) ? vec_t'(5) :
              (op == 5'd13) ? vec_t'(6) : vec_t'(3);
      push(r | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | vec_t'(3),
           rb(), junk, "F0");
      push_wait(r | M_ZLO | M_PCIN | M_RD | M_MDRIN, f1s, junk, "F1");
      push(r | M_MDROUT | M_IRIN, rb(), insn, "F2");
      if (op <= 5'd2) begin
         push(r | M_GRB | M_BAOUT | M_YIN, rb(), insn, "ls.E3");
         push(r | M_COUT | M_ZIN | vec_t'(3), rb(), insn, "ls.E4");
         if (op == 5'd1) begin
            push(r | M_ZLO | M_GRA | M_RIN, rb(), insn, "ldi.E5");
         end else begin
            push(r | M_ZLO | M_MARIN, rb(), insn, "ls.E5");
            if (op == 5'd0) begin
               push_wait(r | M_RD | M_MDRIN, mems, insn, "ld.E6");
               push(r | M_MDROUT | M_GRA | M_RIN, rb(), insn, "ld.E7");
            end else begin
               push(r | M_GRA | M_ROUT | M_MDRIN, rb(), insn, "st.E6");
               push_wait(r | M_WR, mems, insn, "st.E7");
            end
         end
      end else if (op <= 5'd13) begin
         push(r | M_GRB | M_ROUT | M_YIN, rb(), insn, "alu.E3");
         if (op <= 5'd10)
            push(r | M_GRC | M_ROUT | M_ZIN | vec_t'(op), rb(), insn,
                 "alu.E4");
         else
            push(r | M_COUT | M_ZIN | immop, rb(), insn, "imm.E4");
         push(r | M_ZLO | M_GRA | M_RIN, rb(), insn, "alu.E5");
      end else if (op <= 5'd15) begin
         push(r | M_GRA | M_ROUT | M_YIN, rb(), insn, "md.E3");
         push(r | M_GRB | M_ROUT | M_ZIN | vec_t'(op), rb(), insn,
              "md.E4");
         push(r | M_ZLO | M_LOIN, rb(), insn, "md.E5");
         push(r | M_ZHI | M_HIIN, rb(), insn, "md.E6");
      end else if (op == 5'd26) begin
         push(r, rb(), insn, "nop.E3");
      end else if (op == 5'd27) begin
         push(r, rb(), insn, "halt.E3");
         for (int i = 0; i < 20; i++) push('0, rb(), insn, "halt");
      end else begin
         push(r | M_ILL, rb(), insn, "ill.E3");
      end
   endfunction

   // Called mid-cycle; leaves the bench just after the edge into F0.
   task automatic do_reset();
      clear = 1'b1;
      #1;
      chk("rst_async", obs(), M_RUN);
      @(posedge clock);
      #1;
      chk("rst_hold", obs(), M_RUN);
      clear = 1'b0;
      @(negedge clock);
      chk("idle", obs(), M_RUN);
      @(posedge clock);
      #1;
      q.delete();
   endtask

   task automatic run_steps(input int n);
      step_t s;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         s = q.pop_front();
         cs_bus.ir       = s.ir;
         cs_bus.mem_done = s.md;
         @(negedge clock);
         chk(s.tag, obs(), s.exp);
         if (i != n - 1) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic run_insn(input logic [31:0] insn, input int f1s,
                           input int mems);
      build(insn, f1s, mems);
      run_steps(q.size());
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] insn;
      checks          = 0;
      errors          = 0;
      clear           = 1'b1;
      cs_bus.ir       = '0;
      cs_bus.mem_done = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      run_insn(32'h0108_0065, 0, 0);
      run_insn(32'h0108_0065, 3, 3);
      run_insn(32'h1A92_0000, 0, 0);
      run_insn(32'h7000_0000, 0, 0);
      run_insn(32'h7800_0000, 1, 0);
      run_insn(32'h1000_0000, 0, 0);
      run_insn(32'h1000_0000, 0, 2);
      run_insn(32'h0800_1234, 0, 0);
      run_insn(32'h5800_0007, 0, 0);
      run_insn(32'h6000_0007, 0, 0);
      run_insn(32'h6800_0007, 0, 0);
      run_insn(32'hD000_0000, 0, 0);
      run_insn(32'hF800_0000, 0, 0);
      run_insn(32'h8000_0000, 2, 0);

      // Abort an add mid-E4: F0 F1 F2 E3 E4, then clear.
      build(32'h1A92_0000, 0, 0);
      run_steps(5);
      do_reset();

      for (int k = 0; k < 80; k++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         insn = {op, 27'($urandom)};
         run_insn(insn, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      build(32'hD800_0000, 0, 0);
      run_steps(q.size());
      do_reset();
      run_insn(32'h1A92_0000, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
